// File: rtl/net_pkg.sv
// Shared constants and types for the network TX path.
package net_pkg;
   localparam int NET_AXIS_WIDTH = 512;
   localparam int NET_KEEP_WIDTH = 64;
   localparam int NET_BEAT_WIDTH = NET_AXIS_WIDTH + NET_KEEP_WIDTH + 1;

   typedef struct packed {
      logic [NET_AXIS_WIDTH-1:0] data;
      logic [NET_KEEP_WIDTH-1:0] keep;
      logic                      last;
   } net_beat_t;

   typedef enum logic {
      ST_WRITE = 1'b0,
      ST_DROP  = 1'b1
   } wr_state_t;
endpackage

// File: rtl/axi_stream.sv
// AXI-Stream bundle with data, keep, last and valid/ready handshake.
interface axi_stream #(
   parameter int WIDTH = 512
);
   logic [WIDTH-1:0]   data;
   logic [WIDTH/8-1:0] keep;
   logic               last;
   logic               valid;
   logic               ready;

   modport master (output data, keep, last, valid, input ready);
   modport slave  (input data, keep, last, valid, output ready);
endinterface

// File: rtl/net_sdp_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
module net_sdp_ram #(
   parameter int WIDTH = 577,
   parameter int DEPTH = 128
) (
   input  logic                     i_clk,
   input  logic                     i_we,
   input  logic [$clog2(DEPTH)-1:0] i_waddr,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic                     i_re,
   input  logic [$clog2(DEPTH)-1:0] i_raddr,
   output logic [WIDTH-1:0]         o_rdata
);
   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      if (i_re) o_rdata <= r_mem[i_raddr];
   end
endmodule

// File: rtl/net_tx_pkt_fifo.sv
// Store-and-forward TX frame FIFO; frames that cannot fit are
// discarded whole instead of stalling the input.
module net_tx_pkt_fifo
   import net_pkg::*;
#(
   parameter int          DEPTH    = 128,
   parameter logic [31:0] MAX_DROP = 32'hFFFF_FFFF
) (
   input  logic                   net_clk,
   input  logic                   sys_reset,
   axi_stream.slave               s_axis,
   axi_stream.master              m_axis,
   output logic [$clog2(DEPTH):0] pkt_count,
   output logic [31:0]            drop_count,
   output logic                   drop_pulse
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] L_FULL = PW'(DEPTH);

   wr_state_t r_state, w_state_nxt;
   logic [PW-1:0] r_wr_ptr, r_wr_commit, r_rd_ptr;
   logic [PW-1:0] w_wr_inc, w_rd_addr;
   logic w_acc, w_full, w_fill;
   logic w_ram_we, w_commit, w_rewind, w_drop;
   logic r_out_vld, r_skid_vld, r_pend;
   logic w_pop, w_issue;
   logic [1:0] w_occ;
   net_beat_t w_wbeat, w_rbeat, r_out, r_skid;
   logic [NET_BEAT_WIDTH-1:0] w_rdata;

   assign s_axis.ready = ~sys_reset;
   assign w_acc    = s_axis.valid & s_axis.ready;
   assign w_wr_inc = r_wr_ptr + 1'b1;
   assign w_full   = (r_wr_ptr - r_rd_ptr) == L_FULL;
   assign w_fill   = (w_wr_inc - r_rd_ptr) == L_FULL;
   assign w_wbeat  = {s_axis.data, s_axis.keep, s_axis.last};

   always_ff @(posedge net_clk or posedge sys_reset) begin
      if (sys_reset) r_state <= ST_WRITE;
      else           r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_WRITE:
            if (w_acc && !s_axis.last && (w_full || w_fill))
               w_state_nxt = ST_DROP;
         ST_DROP:
            if (w_acc && s_axis.last)
               w_state_nxt = ST_WRITE;
      endcase
   end

   // A last beat on an already-full FIFO loses the frame in one step.
   always_comb begin
      w_ram_we = 1'b0;
      w_commit = 1'b0;
      w_rewind = 1'b0;
      w_drop   = 1'b0;
      unique case (r_state)
         ST_WRITE:
            if (w_acc) begin
               if (w_full) begin
                  w_rewind = 1'b1;
                  w_drop   = s_axis.last;
               end else begin
                  w_ram_we = 1'b1;
                  w_commit = s_axis.last;
                  w_rewind = !s_axis.last && w_fill;
               end
            end
         ST_DROP:
            w_drop = w_acc && s_axis.last;
      endcase
   end

   // rd_ptr trails the output; beats in flight sit at rd_ptr + w_occ.
   assign w_pop     = r_out_vld & m_axis.ready;
   assign w_occ     = {1'b0, r_out_vld} + {1'b0, r_skid_vld} + {1'b0, r_pend};
   assign w_rd_addr = r_rd_ptr + PW'(w_occ);
   assign w_issue   = (w_rd_addr != r_wr_commit) &&
                      ((w_occ - {1'b0, w_pop}) < 2'd2);

   always_ff @(posedge net_clk or posedge sys_reset) begin
      if (sys_reset) begin
         r_wr_ptr    <= '0;
         r_wr_commit <= '0;
         r_rd_ptr    <= '0;
         pkt_count   <= '0;
         drop_count  <= '0;
         drop_pulse  <= 1'b0;
      end else begin
         if (w_rewind)      r_wr_ptr <= r_wr_commit;
         else if (w_ram_we) r_wr_ptr <= w_wr_inc;
         if (w_commit) r_wr_commit <= w_wr_inc;
         if (w_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_commit, w_pop && r_out.last})
            2'b10:   pkt_count <= pkt_count + 1'b1;
            2'b01:   pkt_count <= pkt_count - 1'b1;
            default: pkt_count <= pkt_count;
         endcase
         drop_pulse <= w_drop;
         if (w_drop && drop_count != MAX_DROP)
            drop_count <= drop_count + 32'd1;
      end
   end

   assign w_rbeat = net_beat_t'(w_rdata);

   always_ff @(posedge net_clk or posedge sys_reset) begin
      if (sys_reset) begin
         r_pend     <= 1'b0;
         r_out_vld  <= 1'b0;
         r_skid_vld <= 1'b0;
         r_out      <= '0;
         r_skid     <= '0;
      end else begin
         r_pend <= w_issue;
         if (!r_out_vld || w_pop) begin
            if (r_skid_vld) begin
               r_out      <= r_skid;
               r_out_vld  <= 1'b1;
               r_skid_vld <= r_pend;
               if (r_pend) r_skid <= w_rbeat;
            end else begin
               r_out_vld <= r_pend;
               if (r_pend) r_out <= w_rbeat;
            end
         end else if (r_pend) begin
            r_skid     <= w_rbeat;
            r_skid_vld <= 1'b1;
         end
      end
   end

   assign m_axis.valid = r_out_vld;
   assign m_axis.data  = r_out.data;
   assign m_axis.keep  = r_out.keep;
   assign m_axis.last  = r_out.last;

   net_sdp_ram #(
      .WIDTH (NET_BEAT_WIDTH),
      .DEPTH (DEPTH)
   ) u_ram (
      .i_clk   (net_clk),
      .i_we    (w_ram_we),
      .i_waddr (r_wr_ptr[AW-1:0]),
      .i_wdata (w_wbeat),
      .i_re    (w_issue),
      .i_raddr (w_rd_addr[AW-1:0]),
      .o_rdata (w_rdata)
   );
endmodule
